// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared encodings and widths for the data-memory responder and stall logic.
package dmem_responder_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int WORD_W = 16;
   localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 16 storage with synchronous write, registered read and asynchronous clear.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we) mem[idx] <= wdata;
         if (re) rdata <= mem[idx];
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory slave that stalls the pipeline while an access is in flight.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Rd,
   input  logic              Wr,
   input  logic [15:0]       Addr,
   input  logic [WORD_W-1:0] DataIn,
   output logic [WORD_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              Err
);
   localparam int AW = $clog2(DEPTH);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic op_wr;
   logic [AW-1:0] idx;
   logic [WORD_W-1:0] wdata;
   logic valid, bad, accept, complete;
   logic unused_addr;
   assign unused_addr = ^Addr[15:AW+1];
   assign valid = (Rd ^ Wr) & ~Addr[0];
   assign bad = (Rd | Wr) & ~valid;
   assign Stall = (state == BUSY);
   always_comb begin
      accept = (state == IDLE) && valid;
      complete = (state == BUSY) && (cnt == '0);
      state_n = accept ? BUSY : complete ? IDLE : state;
      cnt_n = accept ? CNT_W'(LATENCY - 1) : (state == BUSY && !complete) ? cnt - 1'b1 : cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         op_wr <= 1'b0;
         idx <= '0;
         wdata <= '0;
         Done <= 1'b0;
         Err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         Done <= complete;
         Err <= (state == IDLE) && bad;
         if (accept) begin
            op_wr <= Wr;
            idx <= Addr[AW:1];
            wdata <= DataIn;
         end
      end
   end
   // the array commits or reads only on the completion edge, so an aborted access leaves no trace
   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (complete & op_wr),
      .re    (complete & ~op_wr),
      .idx   (idx),
      .wdata (wdata),
      .rdata (DataOut)
   );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder at LATENCY 2 and 3.
module tb_dmem_responder;
   logic clk = 0;
   logic rst_i[2];
   logic rd[2], wr[2];
   logic [15:0] addr[2], din[2], dout[2];
   logic done[2], stall[2], err[2];
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst_i[0]), .Rd(rd[0]), .Wr(wr[0]), .Addr(addr[0]), .DataIn(din[0]),
      .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]), .Err(err[0]));
   dmem_responder #(.DEPTH(256), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst_i[1]), .Rd(rd[1]), .Wr(wr[1]), .Addr(addr[1]), .DataIn(din[1]),
      .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]), .Err(err[1]));

   typedef struct {
      logic rd, wr;
      logic [15:0] a, d;
      int kind;
      logic [15:0] dout;
   } vec_t;
   vec_t v[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // kind: 0 = timeout, 1 = Done, 2 = Err; lat counts edges from presentation
   task automatic xact(input int s, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int kind, output int lat, output int stalls);
      @(negedge clk);
      rd[s] = r; wr[s] = w; addr[s] = a; din[s] = d;
      kind = 0; lat = 0; stalls = 0;
      for (int n = 1; n <= 20 && kind == 0; n++) begin
         @(posedge clk); #1;
         if (stall[s]) stalls++;
         if (done[s]) begin kind = 1; lat = n; end
         else if (err[s]) begin kind = 2; lat = n; end
      end
      rd[s] = 0; wr[s] = 0;
   endtask

   task automatic wait_done(input int s, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done[s] && n < 20);
   endtask

   initial begin
      int kind, lat, stalls, n, cnt;
      for (int s = 0; s < 2; s++) begin
         rst_i[s] = 0; rd[s] = 0; wr[s] = 0; addr[s] = 0; din[s] = 0;
      end
      v[0]  = '{1, 0, 16'h0010, 16'h0000, 1, 16'h0000};
      v[1]  = '{0, 1, 16'h0010, 16'hBEEF, 1, 16'h0000};
      v[2]  = '{1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF};
      v[3]  = '{1, 1, 16'h0010, 16'h1111, 2, 16'hBEEF};
      v[4]  = '{1, 0, 16'h0011, 16'h0000, 2, 16'hBEEF};
      v[5]  = '{0, 1, 16'h0002, 16'h1234, 1, 16'hBEEF};
      v[6]  = '{1, 0, 16'h0202, 16'h0000, 1, 16'h1234};
      v[7]  = '{0, 1, 16'h0011, 16'h9999, 2, 16'h1234};
      v[8]  = '{0, 1, 16'h01FE, 16'hA5A5, 1, 16'h1234};
      v[9]  = '{1, 0, 16'h0000, 16'h0000, 1, 16'h0000};
      v[10] = '{1, 0, 16'hFFFE, 16'h0000, 1, 16'hA5A5};
      #2 rst_i[0] = 1; rst_i[1] = 1;
      #1;
      chk("rst_dout", dout[0], 16'h0000);
      chk("rst_done", done[0], 0);
      chk("rst_stall", stall[0], 0);
      chk("rst_err", err[0], 0);
      chk("rst_dout_l3", dout[1], 16'h0000);
      @(negedge clk); rst_i[0] = 0; rst_i[1] = 0;

      for (int i = 0; i < 11; i++) begin
         xact(0, v[i].rd, v[i].wr, v[i].a, v[i].d, kind, lat, stalls);
         chk($sformatf("v%0d_kind", i), kind, v[i].kind);
         chk($sformatf("v%0d_lat", i), lat, v[i].kind == 1 ? 3 : 1);
         chk($sformatf("v%0d_stall", i), stalls, v[i].kind == 1 ? 2 : 0);
         chk($sformatf("v%0d_dout", i), dout[0], v[i].dout);
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse_err", i), err[0], 0);
         chk($sformatf("v%0d_pulse_done", i), done[0], 0);
      end

      // request switched while busy
      xact(0, 0, 1, 16'h0004, 16'h4444, kind, lat, stalls);
      chk("w4_kind", kind, 1);
      xact(0, 0, 1, 16'h0006, 16'h6666, kind, lat, stalls);
      chk("w6_kind", kind, 1);
      @(negedge clk); rd[0] = 1; addr[0] = 16'h0004;
      @(posedge clk); #1;
      chk("chg_stall", stall[0], 1);
      rd[0] = 0; wr[0] = 1; addr[0] = 16'h0006; din[0] = 16'hDEAD;
      wait_done(0, n);
      wr[0] = 0;
      chk("chg_done", done[0], 1);
      chk("chg_lat", n, 2);
      chk("chg_dout", dout[0], 16'h4444);
      xact(0, 1, 0, 16'h0006, 16'h0000, kind, lat, stalls);
      chk("chg_w6_kind", kind, 1);
      chk("chg_w6_dout", dout[0], 16'h6666);

      // back-to-back reads under a held request
      @(negedge clk); rd[0] = 1; addr[0] = 16'h0004;
      wait_done(0, n);
      chk("b2b_first", done[0], 1);
      wait_done(0, n);
      rd[0] = 0;
      chk("b2b_second", done[0], 1);
      chk("b2b_gap", n, 3);
      chk("b2b_dout", dout[0], 16'h4444);

      // asynchronous reset in the middle of a read
      @(negedge clk); rd[0] = 1; addr[0] = 16'h0010;
      @(posedge clk); #1;
      chk("mid_stall", stall[0], 1);
      #2 rst_i[0] = 1;
      #1;
      chk("mid_dout", dout[0], 16'h0000);
      chk("mid_stall_clr", stall[0], 0);
      chk("mid_done", done[0], 0);
      rd[0] = 0;
      @(negedge clk); rst_i[0] = 0;
      xact(0, 1, 0, 16'h0010, 16'h0000, kind, lat, stalls);
      chk("post_rst_kind", kind, 1);
      chk("post_rst_dout", dout[0], 16'h0000);

      // LATENCY 3: reset one cycle after accepting a write
      @(negedge clk); wr[1] = 1; addr[1] = 16'h0020; din[1] = 16'h5555;
      @(posedge clk); #1;
      chk("l3_acc_stall", stall[1], 1);
      wr[1] = 0;
      @(posedge clk);
      @(negedge clk); rst_i[1] = 1;
      @(negedge clk); rst_i[1] = 0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done[1]) cnt++;
      end
      chk("l3_abort_done", cnt, 0);
      xact(1, 1, 0, 16'h0020, 16'h0000, kind, lat, stalls);
      chk("l3_rd_kind", kind, 1);
      chk("l3_rd_lat", lat, 4);
      chk("l3_rd_stall", stalls, 3);
      chk("l3_rd_dout", dout[1], 16'h0000);
      xact(1, 0, 1, 16'h0020, 16'h5555, kind, lat, stalls);
      chk("l3_wr_lat", lat, 4);
      xact(1, 1, 0, 16'h0020, 16'h0000, kind, lat, stalls);
      chk("l3_rd2_dout", dout[1], 16'h5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. It replaces the single-cycle data memory with a fixed-latency slave. It accepts one word request at a time, raises Stall while the access is in flight, and pulses Done with read data when the access completes. The pipeline freezes its EX/MEM and MEM/WB registers on Stall; this block supplies that stall source.

Parameters:
DEPTH, 256, number of 16-bit words stored; must be a power of two.
LATENCY, 2, cycles from the accepting edge to the Done cycle; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
Rd  in  1  read request, level, held by requester until Done
Wr  in  1  write request, level, held by requester until Done
Addr  in  16  byte address; word index = Addr[log2(DEPTH):1]
DataIn  in  16  write data, sampled at the accepting edge
DataOut  out  16  read data, registered
Done  out  1  one-cycle completion pulse, registered
Stall  out  1  access in flight; requester must hold its request
Err  out  1  one-cycle error pulse, registered

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst, all of the following happen immediately, regardless of clock:
  - state is set to IDLE and the counter is cleared;
  - DataOut = 0, Done = 0, Stall = 0, Err = 0;
  - all DEPTH words are cleared to 0.
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight; a latched request is waiting for its completion edge.
- Valid request: exactly one of Rd/Wr high, and Addr[0] = 0.
- Acceptance: at a rising edge in IDLE with a valid request:
  - latch op, word index and DataIn;
  - load the counter with LATENCY-1;
  - go to BUSY.
- Bad request: at a rising edge in IDLE with Rd & Wr both high, or (Rd|Wr) & Addr[0] = 1:
  - Err = 1 for the following cycle;
  - no access, no state change, Done stays 0.
- BUSY: the counter decrements each edge. On the edge where the counter is 0 (the completion edge), the block:
  - performs the write to the array, or loads DataOut with the array word;
  - sets Done = 1 for exactly one cycle;
  - returns to IDLE.
- Timing: the completion edge is exactly LATENCY edges after the accepting edge.
- Stall = (state == BUSY), registered. It is high from the accepting edge until the completion edge, i.e. for LATENCY cycles. It is low in the Done cycle.
- Requests seen while BUSY are ignored. Rd/Wr/Addr/DataIn changes during BUSY do not affect the latched access.
- Back-to-back: a valid request present during the Done cycle is accepted at the next edge. Maximum throughput is one access per LATENCY+1 cycles.
- DataOut holds its value until the next read completes. Writes never change DataOut.
- Address wrap: addresses at or beyond 2*DEPTH alias modulo DEPTH words. Upper address bits are ignored without error.
- Write-then-read to the same word returns the new data. The write commits at its completion edge, before the read can be accepted.
- Reset mid-BUSY: the access is aborted and a pending write is not committed. Done is not produced.
- No request in IDLE: all pulses stay 0 and the state holds.

Decomposition:
- Shared package, imported by the pipeline stall logic:
  - state encodings IDLE = 1'b0, BUSY = 1'b1;
  - word width constant 16;
  - latency counter width 4.
- One natural sub-module, dmem_array: a DEPTH x 16 storage array with synchronous write, registered read and asynchronous clear on rst. The responder FSM and counter stay in dmem_responder.

Test Plan:
- Reset: assert rst mid-cycle -> DataOut = 0, Done = 0, Stall = 0, Err = 0 immediately. Read of Addr 0x0010 after release returns 0x0000.
- Write then read, LATENCY = 2:
  - Wr, Addr = 0x0010, DataIn = 0xBEEF -> Stall high for 2 cycles, then Done for 1 cycle.
  - Rd, Addr = 0x0010 -> Done in the 3rd cycle after request presentation, DataOut = 0xBEEF.
- Errors:
  - Rd = Wr = 1 -> Err pulse of 1 cycle, no Done, no Stall.
  - Rd, Addr = 0x0011 -> Err pulse, and DataOut is unchanged.
- Wrap, DEPTH = 256: write 0x1234 to Addr 0x0002, then read Addr 0x0202 -> DataOut = 0x1234.
- Request change during BUSY: a read of 0x0004 is accepted, then the bench switches to Wr, Addr 0x0006 while Stall is high -> the completed access is the read of 0x0004 only. Word 0x0006 is unmodified.
- Reset mid-write, LATENCY = 3: Wr 0x5555 to 0x0020, rst pulsed one cycle after acceptance -> no Done. A later read of 0x0020 returns 0x0000.
